// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder tree.
//
// Contents:
//   clog2 : ceiling log2, used at elaboration time to derive the number of
//           tree levels from the operand count.
package adder_pkg;

  // Ceiling log2 for positive values; clog2(1) = 0, clog2(8) = 3.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One level of the pipelined adder tree.
//
// Sums PAIRS adjacent operand pairs. Each operand is widened by one bit before
// the add, so the result cannot overflow. The sums and a valid bit are
// registered. Registers load only when en is high.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, clears data and valid
//   en        : pipeline advance enable
//   valid_in  : valid bit of the incoming operand vector
//   din       : 2*PAIRS operands of IN_WIDTH bits, operand k at [k*IN_WIDTH +: IN_WIDTH]
//   valid_out : registered valid bit
//   dout      : PAIRS sums of IN_WIDTH+1 bits, sum j at [j*(IN_WIDTH+1) +: IN_WIDTH+1]
module adder_tree_stage
  import adder_pkg::*;
#(
  parameter int PAIRS    = 4,
  parameter int IN_WIDTH = 8,
  parameter int SIGNED   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            valid_in,
  input  logic [2*PAIRS*IN_WIDTH-1:0]     din,
  output logic                            valid_out,
  output logic [PAIRS*(IN_WIDTH+1)-1:0]   dout
);

  localparam int SUM_WIDTH = IN_WIDTH + 1;

  logic [PAIRS*SUM_WIDTH-1:0] sum_next;
  logic [PAIRS*SUM_WIDTH-1:0] dout_reg;
  logic                       valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PAIRS; gi++) begin : g_pair
      logic [IN_WIDTH-1:0]  lhs;
      logic [IN_WIDTH-1:0]  rhs;
      logic [SUM_WIDTH-1:0] lhs_ext;
      logic [SUM_WIDTH-1:0] rhs_ext;

      assign lhs = din[(2*gi)*IN_WIDTH +: IN_WIDTH];
      assign rhs = din[(2*gi+1)*IN_WIDTH +: IN_WIDTH];

      if (SIGNED != 0) begin : g_sext
        assign lhs_ext = {lhs[IN_WIDTH-1], lhs};
        assign rhs_ext = {rhs[IN_WIDTH-1], rhs};
      end else begin : g_zext
        assign lhs_ext = {1'b0, lhs};
        assign rhs_ext = {1'b0, rhs};
      end

      assign sum_next[gi*SUM_WIDTH +: SUM_WIDTH] = lhs_ext + rhs_ext;
    end
  endgenerate

  // Data loads even when valid_in is low; downstream qualifies it with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      dout_reg  <= sum_next;
      valid_reg <= valid_in;
    end
  end

  assign dout      = dout_reg;
  assign valid_out = valid_reg;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined adder tree with valid/ready handshaking.
//
// Adds ADDER_NUM operands of ADDER_WIDTH bits through LEVELS = log2(ADDER_NUM)
// registered levels. The result is exact (OUT_WIDTH = ADDER_WIDTH + LEVELS).
// The whole pipeline advances together: a stall at the output freezes every
// level, including empty ones. Latency is LEVELS cycles and throughput is
// one vector per cycle when out_ready stays high.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset, discards all in-flight vectors
//   in_valid   : operand vector valid
//   in_ready   : vector accepted this cycle if in_valid is also high
//   adder_din  : operand k at [k*ADDER_WIDTH +: ADDER_WIDTH]
//   out_valid  : sum valid
//   out_ready  : downstream accepts sum
//   adder_dout : sum of all operands
module adder_tree_pipe
  import adder_pkg::*;
#(
  parameter  int ADDER_NUM   = 8,
  parameter  int ADDER_WIDTH = 8,
  parameter  int SIGNED      = 0,
  localparam int LEVELS      = clog2(ADDER_NUM),
  localparam int OUT_WIDTH   = ADDER_WIDTH + LEVELS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ADDER_NUM*ADDER_WIDTH-1:0] adder_din,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             adder_dout
);

  // The pairwise tree only works for a power-of-two operand count.
  generate
    if ((ADDER_NUM < 2) || ((ADDER_NUM & (ADDER_NUM - 1)) != 0)) begin : g_bad_adder_num
      $error("adder_tree_pipe: ADDER_NUM must be a power of two and at least 2");
    end
  endgenerate

  // Single advance enable for every level: move whenever the output slot is
  // empty or is being drained this cycle.
  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
      localparam int IN_W  = ADDER_WIDTH + gi - 1;
      localparam int PAIRS = ADDER_NUM >> gi;

      logic [2*PAIRS*IN_W-1:0]   stage_din;
      logic                      stage_vin;
      logic [PAIRS*(IN_W+1)-1:0] data;
      logic                      valid;

      if (gi == 1) begin : g_first
        assign stage_din = adder_din;
        assign stage_vin = in_valid;
      end else begin : g_inner
        assign stage_din = g_lvl[gi-1].data;
        assign stage_vin = g_lvl[gi-1].valid;
      end

      adder_tree_stage #(
        .PAIRS    (PAIRS),
        .IN_WIDTH (IN_W),
        .SIGNED   (SIGNED)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .valid_in  (stage_vin),
        .din       (stage_din),
        .valid_out (valid),
        .dout      (data)
      );
    end
  endgenerate

  // The last level holds exactly one sum of OUT_WIDTH bits.
  assign out_valid  = g_lvl[LEVELS].valid;
  assign adder_dout = g_lvl[LEVELS].data;

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 SHALL have parameter ADDER_NUM, default 8, number of operands (power of two, >=2).
REQ-002 SHALL have parameter ADDER_WIDTH, default 8, width of each operand.
REQ-003 SHALL have parameter SIGNED, default 0, 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 SHALL define LEVELS = log2(ADDER_NUM) and OUT_WIDTH = ADDER_WIDTH + LEVELS as localparams.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  operand vector valid.
REQ-008 in_ready  output  1  block accepts operand vector this cycle.
REQ-009 adder_din  input  ADDER_NUM*ADDER_WIDTH  operand k at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
REQ-010 out_valid  output  1  sum valid.
REQ-011 out_ready  input  1  downstream accepts sum.
REQ-012 adder_dout  output  OUT_WIDTH  sum of all ADDER_NUM operands.

Function
REQ-013 Tree SHALL have LEVELS registered stages; stage L (1..LEVELS) holds ADDER_NUM>>L partial sums of width ADDER_WIDTH+L.
REQ-014 Stage L sum j SHALL equal stage L-1 entry 2j + entry 2j+1, each extended by one bit before adding (zero-extend if SIGNED=0, sign-extend if SIGNED=1); stage 0 is adder_din.
REQ-015 Result SHALL be exact; no overflow or truncation for any operand values.
REQ-016 Each stage SHALL carry a valid bit alongside its data.
REQ-017 Global advance enable SHALL be adv = ~out_valid | out_ready; all stage data and valid registers update only when adv=1.
REQ-018 in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-019 On adv=1, stage-1 valid SHALL load in_valid; stage-L valid loads stage-(L-1) valid.
REQ-020 Data registers of a stage MAY load when its incoming valid is 0; consumers SHALL ignore data whose valid is 0.
REQ-021 out_valid SHALL be stage-LEVELS valid; adder_dout SHALL be stage-LEVELS data.
REQ-022 Latency SHALL be exactly LEVELS cycles from accepted input (in_valid & in_ready) to out_valid when out_ready stays 1.
REQ-023 Throughput SHALL be one vector per cycle when out_ready stays 1.
REQ-024 While out_valid=1 and out_ready=0, adder_dout and out_valid SHALL hold stable, in_ready=0, no stage changes.
REQ-025 Bubbles are not collapsed: a stall freezes the whole pipeline including empty stages.
REQ-026 Simultaneous in_valid and output pop in one cycle SHALL both complete (accept and retire).
REQ-027 Vectors SHALL exit in acceptance order; none dropped or duplicated.

Reset
REQ-028 rst_n low SHALL asynchronously clear all valid bits and all data registers to 0.
REQ-029 During and directly after reset: out_valid=0, adder_dout=0, in_ready=1.
REQ-030 Reset mid-operation SHALL discard all in-flight vectors; no output appears for them after release.

Structure
REQ-031 Shared package adder_pkg SHALL provide a clog2 function used to derive LEVELS.
REQ-032 One sub-module adder_tree_stage SHALL implement one level (parametrised pair count, input width, SIGNED, enable, valid in/out); adder_tree_pipe instantiates LEVELS of them via generate.
REQ-033 Elaboration SHALL fail if ADDER_NUM is not a power of two or is below 2.

Verification
REQ-034 ADDER_NUM=4, ADDER_WIDTH=8, SIGNED=0, all operands 8'hFF, out_ready=1 -> adder_dout=10'd1020, out_valid exactly 2 cycles after acceptance.
REQ-035 Same params, SIGNED=1, all operands 8'h80 -> adder_dout=10'h200 (-512); operands {8'h7F,8'h81,8'h01,8'hFF} -> 10'h000.
REQ-036 Default params, 16 back-to-back vectors (operand k = vector index + k), out_ready=1 -> 16 consecutive out_valid cycles, sums 28+8i in order.
REQ-037 Hold out_ready=0 for 5 cycles while output valid and in_valid=1 -> in_ready=0, adder_dout stable; after release, no vector lost or duplicated.
REQ-038 Assert rst_n=0 with 3 vectors in flight -> out_valid=0, adder_dout=0 immediately; after release, no stale outputs.
REQ-039 Random in_valid/out_ready (50%) for 1000 vectors, random operands, both SIGNED settings -> every output matches reference model sum, order preserved.
